// File: rtl/seg7_readback_decoder_if.sv
// Decoded-index handoff bus: valid/ready with an 8-bit index payload.
interface seg7_readback_decoder_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_idx;

  modport master (output out_valid, output out_idx, input out_ready);
  modport slave  (input out_valid, input out_idx, output out_ready);
endinterface

// File: rtl/seg7_readback_decoder.sv
// Decodes two stable active-low 7-seg digits back to an index; valid rises STABLE_CYCLES+1 edges after a new pattern.
// Holds out_idx/out_valid until out_ready; input changes meanwhile are tracked but only the newest stable pattern is decoded.
module seg7_readback_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              hex0,
  input  logic [6:0]              hex1,
  seg7_readback_decoder_if.master dout,
  output logic                    err_pulse,
  output logic [ERR_W-1:0]        err_count
);
  typedef enum logic [1:0] {ST_WAIT, ST_DECODE, ST_OFFER} state_t;

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);

  state_t      state, state_nxt;
  logic [13:0] smp, smp_nxt, last;
  logic        have_last;
  logic [7:0]  stab_cnt, stab_nxt;
  logic [4:0]  dec_hi, dec_lo;
  logic        load_last, load_out, err_inc, clr_valid;

  // bit4 = pattern valid, bits3:0 = nibble
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'h40:   return 5'h10;
      7'h79:   return 5'h11;
      7'h24:   return 5'h12;
      7'h30:   return 5'h13;
      7'h19:   return 5'h14;
      7'h12:   return 5'h15;
      7'h02:   return 5'h16;
      7'h78:   return 5'h17;
      7'h00:   return 5'h18;
      7'h18:   return 5'h19;
      7'h08:   return 5'h1A;
      7'h03:   return 5'h1B;
      7'h46:   return 5'h1C;
      7'h21:   return 5'h1D;
      7'h06:   return 5'h1E;
      7'h0E:   return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  assign smp_nxt = {hex1, hex0};
  assign dec_hi  = seg_decode(last[13:7]);
  assign dec_lo  = seg_decode(last[6:0]);

  // Looking at the post-edge count lets DECODE start right at edge E0+STABLE_CYCLES.
  always_comb begin
    stab_nxt = 8'd0;
    if (smp_nxt != smp) begin
      stab_nxt = 8'd0;
    end else if (stab_cnt == STAB_MAX) begin
      stab_nxt = stab_cnt;
    end else begin
      stab_nxt = stab_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_last = 1'b0;
    load_out  = 1'b0;
    err_inc   = 1'b0;
    clr_valid = 1'b0;
    err_pulse = 1'b0;
    case (state)
      ST_WAIT: begin
        if (stab_nxt == STAB_MAX && (!have_last || smp_nxt != last)) begin
          load_last = 1'b1;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_hi[4] && dec_lo[4]) begin
          load_out  = 1'b1;
          state_nxt = ST_OFFER;
        end else begin
          err_pulse = 1'b1;
          err_inc   = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_OFFER: begin
        if (dout.out_valid && dout.out_ready) begin
          clr_valid = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      default: state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp            <= 14'h3FFF;
      stab_cnt       <= 8'd0;
      last           <= 14'h3FFF;
      have_last      <= 1'b0;
      dout.out_valid <= 1'b0;
      dout.out_idx   <= 8'h00;
      err_count      <= '0;
    end else begin
      smp      <= smp_nxt;
      stab_cnt <= stab_nxt;
      if (load_last) begin
        last      <= smp_nxt;
        have_last <= 1'b1;
      end
      if (load_out) begin
        dout.out_idx   <= {dec_hi[3:0], dec_lo[3:0]};
        dout.out_valid <= 1'b1;
      end else if (clr_valid) begin
        dout.out_valid <= 1'b0;
      end
      if (err_inc && err_count != '1) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Directed and randomized checks of the 7-seg read-back decoder against a pattern-level model.
module tb_seg7_readback_decoder;
  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] hex0, hex1;
  logic       err_pulse, err_pulse2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  seg7_readback_decoder_if bus ();
  seg7_readback_decoder_if bus2 ();
  assign bus2.out_ready = 1'b1;

  seg7_readback_decoder #(.STABLE_CYCLES(S), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .hex0(hex0), .hex1(hex1),
    .dout(bus.master), .err_pulse(err_pulse), .err_count(err_count));

  seg7_readback_decoder #(.STABLE_CYCLES(S), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .hex0(hex0), .hex1(hex1),
    .dout(bus2.master), .err_pulse(err_pulse2), .err_count(err_count2));

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_assert = 0;
  int         n_fail = 0;
  int         n_pulse = 0;
  int         n_overlap = 0;
  int         last_rise = -1;
  logic       prev_valid = 1'b0;
  logic [7:0] got[$];
  logic [6:0] seg [16];

  always @(posedge clk) cyc <= cyc + 1;

  // Transfers and pulses are observed mid-cycle, one half-period before the edge that commits them.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_idx);
      if (err_pulse) n_pulse++;
      if (err_pulse && bus.out_valid) n_overlap++;
      if (bus.out_valid && !prev_valid) last_rise = cyc;
    end
    prev_valid = bus.out_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] idx);
    hex1 = seg[idx[7:4]];
    hex0 = seg[idx[3:0]];
  endtask

  function automatic int nib_of(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (seg[i] == p) return i;
    return -1;
  endfunction

  initial begin
    int         e0, base, pbase, exp_err;
    logic [7:0] pool [6];
    logic [6:0] bad [4];
    logic [13:0] seg_pat[$], last_pat, pat;
    int          seg_len[$];
    logic [7:0]  exp_q[$];

    seg  = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    pool = '{8'h12, 8'h9A, 8'h12, 8'h3C, 8'hE7, 8'h9A};
    bad  = '{7'h7F, 7'h01, 7'h7E, 7'h55};

    // Reset state, then latency and single transfer of 0x2F.
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    hex1 = 7'h24;
    hex0 = 7'h0E;
    step(3);
    check("rst_valid", bus.out_valid, 0);
    check("rst_idx", bus.out_idx, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_count", err_count, 0);
    rst_n = 1'b1;
    e0 = cyc + 1;
    step(20);
    check("t1_latency", last_rise, e0 + S + 1);
    check("t1_count", got.size(), 1);
    if (got.size() > 0) check("t1_idx", got[0], 8'h2F);

    // Backpressure: pending value frozen while the input moves on.
    bus.out_ready = 1'b0;
    base = got.size();
    drive(8'h10);
    step(S + 3);
    check("t2_valid", bus.out_valid, 1);
    check("t2_idx", bus.out_idx, 8'h10);
    drive(8'h34);
    step(10);
    check("t2_hold_idx", bus.out_idx, 8'h10);
    check("t2_hold_valid", bus.out_valid, 1);
    check("t2_no_xfer", got.size(), base);
    bus.out_ready = 1'b1;
    step(15);
    check("t2_count", got.size(), base + 2);
    if (got.size() == base + 2) begin
      check("t2_first", got[base], 8'h10);
      check("t2_second", got[base + 1], 8'h34);
    end

    // Glitches of 2 samples never decode.
    base  = got.size();
    pbase = n_pulse;
    hex1  = seg[5];
    for (int k = 0; k < 20; k++) begin
      hex0 = seg[k % 2];
      step(2);
    end
    check("t3_glitch_xfer", got.size(), base);
    check("t3_glitch_err", n_pulse, pbase);
    hex0 = seg[6];
    step(S + 10);
    check("t3_count", got.size(), base + 1);
    if (got.size() == base + 1) check("t3_idx", got[base], 8'h56);

    // Invalid patterns: counted once each, never forwarded, saturation on ERR_W=2.
    rst_n = 1'b0;
    hex1  = 7'h7F;
    hex0  = 7'h7F;
    step(2);
    rst_n = 1'b1;
    base  = got.size();
    pbase = n_pulse;
    step(S + 6);
    check("t4_pulse", n_pulse - pbase, 1);
    check("t4_count", err_count, 1);
    step(300);
    check("t4_count_hold", err_count, 1);
    check("t4_pulse_hold", n_pulse - pbase, 1);
    hex1 = 7'h40;                  step(S + 6);
    hex1 = 7'h01; hex0 = 7'h40;    step(S + 6);
    hex1 = 7'h7E; hex0 = 7'h7E;    step(S + 6);
    hex1 = 7'h55; hex0 = 7'h55;    step(S + 6);
    check("t4_count5", err_count, 5);
    check("t4_sat_w2", err_count2, 3);
    check("t4_pulse5", n_pulse - pbase, 5);
    check("t4_no_xfer", got.size(), base);

    // Reset during OFFER drops the pending value; first stable pattern after reset re-emits.
    bus.out_ready = 1'b0;
    drive(8'hAB);
    step(S + 3);
    check("t5_valid", bus.out_valid, 1);
    check("t5_idx", bus.out_idx, 8'hAB);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", bus.out_valid, 0);
    check("t5_rst_idx", bus.out_idx, 0);
    check("t5_rst_errcnt", err_count, 0);
    step(2);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    base = got.size();
    step(15);
    check("t5_count", got.size(), base + 1);
    if (got.size() == base + 1) check("t5_idx_again", got[base], 8'hAB);

    // Full index sweep.
    base  = got.size();
    pbase = n_pulse;
    for (int i = 0; i < 256; i++) begin
      drive(8'(i));
      step(S + 4);
    end
    check("t6_count", got.size(), base + 256);
    if (got.size() == base + 256)
      for (int i = 0; i < 256; i++) check("t6_seq", got[base + i], i);
    check("t6_no_err", n_pulse, pbase);

    // Random pattern stream with glitches and repeats, ready held high.
    for (int k = 0; k < 60; k++) begin
      int len;
      logic [7:0] id;
      id = pool[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) < 8) pat = {seg[id[7:4]], seg[id[3:0]]};
      else pat = {seg[id[7:4]], bad[$urandom_range(0, 3)]};
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, S) : $urandom_range(S + 1, S + 6);
      if (seg_pat.size() > 0 && seg_pat[$] == pat) seg_len[$] += len;
      else begin
        seg_pat.push_back(pat);
        seg_len.push_back(len);
      end
    end
    seg_len[$] += S + 6;

    last_pat = {seg[15], seg[15]};
    exp_err  = 0;
    foreach (seg_pat[k]) begin
      if (seg_len[k] >= S + 1 && seg_pat[k] != last_pat) begin
        if (nib_of(seg_pat[k][13:7]) >= 0 && nib_of(seg_pat[k][6:0]) >= 0)
          exp_q.push_back(8'((nib_of(seg_pat[k][13:7]) << 4) | nib_of(seg_pat[k][6:0])));
        else
          exp_err++;
        last_pat = seg_pat[k];
      end
    end

    base  = got.size();
    pbase = n_pulse;
    foreach (seg_pat[k]) begin
      hex1 = seg_pat[k][13:7];
      hex0 = seg_pat[k][6:0];
      step(seg_len[k]);
    end
    check("rnd_count", got.size() - base, exp_q.size());
    if (got.size() - base == exp_q.size())
      foreach (exp_q[k]) check("rnd_seq", got[base + k], exp_q[k]);
    check("rnd_pulses", n_pulse - pbase, exp_err);
    check("rnd_errcnt", err_count, exp_err);
    check("no_overlap", n_overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
